// File: rtl/datamemory_hs_if.sv
// Request/response handshake bundle for the handshaked data memory.
// Master drives requests and rsp_ready; slave answers.
interface datamemory_hs_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_re;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_re, req_we,
    output req_addr, req_wdata, req_funct3,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_re, req_we,
    input  req_addr, req_wdata, req_funct3,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/datamemory_hs.sv
// RV32 byte-addressed data memory with valid/ready handshake and read latency.
// Define DM_MISALIGN_TRAP_EN to flag misaligned accesses as illegal.
module datamemory_hs #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  datamemory_hs_if.slave  bus
);
  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  if (DATA_W != 32) begin : g_dw_chk
    $error("datamemory_hs: DATA_W must be 32");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_chk
    $error("datamemory_hs: RD_LATENCY must be 1..4");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] ld_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH];

  logic [2:0]  f3;
  logic [1:0]  lane;
  logic [DM_ADDRESS-3:0] widx;
  logic        is_ld;
  logic        is_st;
  logic        half;
  logic        word;
  logic        f3_ok;
  logic        mis;
  logic        illegal;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rword;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] ld_data;
  logic        accept;
  logic        do_write;

  assign f3     = bus.req_funct3;
  assign lane   = bus.req_addr[1:0];
  assign widx   = bus.req_addr[DM_ADDRESS-1:2];
  assign accept = bus.req_valid & req_ready_q;

  always_comb begin
    is_ld = bus.req_re & ~bus.req_we;
    is_st = bus.req_we & ~bus.req_re;
    half  = (f3[1:0] == 2'b01);
    word  = (f3[1:0] == 2'b10);
    f3_ok = 1'b0;
    if (is_ld) begin
      f3_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (is_st) begin
      f3_ok = f3 inside {3'b000, 3'b001, 3'b010};
    end
    mis = (half & lane[0]) | (word & (|lane));
`ifdef DM_MISALIGN_TRAP_EN
    illegal = ~f3_ok | mis;
    off     = lane;
`else
    illegal = ~f3_ok;
    off     = word ? 2'b00 : (half ? {lane[1], 1'b0} : lane);
`endif
  end

  always_comb begin
    be   = 4'hf;
    wrep = bus.req_wdata;
    case (f3[1:0])
      2'b00: begin
        be   = 4'b0001 << off;
        wrep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << off;
        wrep = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be   = 4'hf;
        wrep = bus.req_wdata;
      end
    endcase
  end

  // Combinational read of the addressed word; sampled on the accept edge.
  always_comb begin
    rword = mem[widx];
    lbyte = rword[{off, 3'b000} +: 8];
    lhalf = off[1] ? rword[31:16] : rword[15:0];
    case (f3)
      3'b000:  ld_data = {{24{lbyte[7]}}, lbyte};
      3'b001:  ld_data = {{16{lhalf[15]}}, lhalf};
      3'b100:  ld_data = {24'h0, lbyte};
      3'b101:  ld_data = {16'h0, lhalf};
      default: ld_data = rword;
    endcase
  end

  assign do_write = accept & is_st & ~illegal;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wrep[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ld_q        <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (illegal || is_st) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= illegal;
            end else if (RD_LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= ld_data;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 2'(RD_LATENCY - 2);
              ld_q    <= ld_data;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_q;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_datamemory_hs.sv
// Directed bench: one DUT at RD_LATENCY=1, one at RD_LATENCY=3.
// Expected values are hand-computed load/store results.
module tb_datamemory_hs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datamemory_hs_if #(.DM_ADDRESS(9), .DATA_W(32)) if1 ();
  datamemory_hs_if #(.DM_ADDRESS(9), .DATA_W(32)) if3 ();

  datamemory_hs #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );
  datamemory_hs #(.DM_ADDRESS(9), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave)
  );

  task automatic xact(input bit s3, input logic re, input logic we,
                      input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    if (s3) begin
      if3.req_valid = 1'b1; if3.req_re = re; if3.req_we = we;
      if3.req_addr = a; if3.req_wdata = wd; if3.req_funct3 = f;
      if3.rsp_ready = 1'b1;
    end else begin
      if1.req_valid = 1'b1; if1.req_re = re; if1.req_we = we;
      if1.req_addr = a; if1.req_wdata = wd; if1.req_funct3 = f;
      if1.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    if (s3) if3.req_valid = 1'b0;
    else if1.req_valid = 1'b0;
    lat = 1;
    while (!(s3 ? if3.rsp_valid : if1.rsp_valid) && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = s3 ? if3.rsp_rdata : if1.rsp_rdata;
    er = s3 ? if3.rsp_err : if1.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (if1.req_ready !== 1'b1 || if1.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs1 got rdy=%b vld=%b exp rdy=1 vld=0",
               if1.req_ready, if1.rsp_valid);
    end
    checks++;
    if (if1.rsp_rdata !== 32'h0 || if1.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_data1 got rdata=%h err=%b exp 0/0",
               if1.rsp_rdata, if1.rsp_err);
    end
    checks++;
    if (if3.req_ready !== 1'b1 || if3.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs3 got rdy=%b vld=%b exp rdy=1 vld=0",
               if3.req_ready, if3.rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lt;
    xact(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lt != 1) begin
      failures++;
      $display("FAIL sw_rsp got rdata=%h err=%b lat=%0d exp 0/0/1",
               rd, er, lt);
    end
    xact(0, 1, 0, 9'h010, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lt != 1) begin
      failures++;
      $display("FAIL lw_rsp got rdata=%h err=%b lat=%0d exp deadbeef/0/1",
               rd, er, lt);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lt;
    xact(0, 1, 0, 9'h011, 32'h0, 3'b010, rd, er, lt);
    checks++;
`ifdef DM_MISALIGN_TRAP_EN
    if (rd !== 32'h0 || er !== 1'b1) begin
      failures++;
      $display("FAIL lw_mis got rdata=%h err=%b exp 0/1", rd, er);
    end
`else
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL lw_mis got rdata=%h err=%b exp deadbeef/0", rd, er);
    end
`endif
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lt;
    xact(0, 0, 1, 9'h010, 32'h0, 3'b010, rd, er, lt);
    xact(0, 0, 1, 9'h013, 32'h12345680, 3'b000, rd, er, lt);
    xact(0, 1, 0, 9'h013, 32'h0, 3'b000, rd, er, lt);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      failures++;
      $display("FAIL lb got rdata=%h err=%b exp ffffff80/0", rd, er);
    end
    xact(0, 1, 0, 9'h013, 32'h0, 3'b100, rd, er, lt);
    checks++;
    if (rd !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu got rdata=%h exp 00000080", rd);
    end
    xact(0, 1, 0, 9'h010, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h80000000) begin
      failures++;
      $display("FAIL sb_lane got rdata=%h exp 80000000", rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lt;
    xact(0, 0, 1, 9'h020, 32'h0, 3'b010, rd, er, lt);
    xact(0, 0, 1, 9'h022, 32'hABCD8001, 3'b001, rd, er, lt);
    xact(0, 1, 0, 9'h022, 32'h0, 3'b001, rd, er, lt);
    checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
      failures++;
      $display("FAIL lh got rdata=%h err=%b exp ffff8001/0", rd, er);
    end
    xact(0, 1, 0, 9'h022, 32'h0, 3'b101, rd, er, lt);
    checks++;
    if (rd !== 32'h00008001) begin
      failures++;
      $display("FAIL lhu got rdata=%h exp 00008001", rd);
    end
    xact(0, 1, 0, 9'h020, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h80010000) begin
      failures++;
      $display("FAIL sh_lane got rdata=%h exp 80010000", rd);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lt;
    xact(0, 0, 1, 9'h030, 32'h11223344, 3'b010, rd, er, lt);
    xact(0, 1, 1, 9'h030, 32'hFFFFFFFF, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || lt != 1) begin
      failures++;
      $display("FAIL ill_rewe got rdata=%h err=%b lat=%0d exp 0/1/1",
               rd, er, lt);
    end
    xact(0, 0, 0, 9'h030, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL ill_none got err=%b exp 1", er);
    end
    xact(0, 1, 0, 9'h030, 32'h0, 3'b011, rd, er, lt);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      failures++;
      $display("FAIL ill_ldf3 got rdata=%h err=%b exp 0/1", rd, er);
    end
    xact(0, 0, 1, 9'h030, 32'hFFFFFFFF, 3'b100, rd, er, lt);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL ill_stf3 got err=%b exp 1", er);
    end
    xact(0, 1, 0, 9'h030, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      failures++;
      $display("FAIL ill_nowrite got rdata=%h err=%b exp 11223344/0",
               rd, er);
    end
  endtask

  task automatic test_latency3();
    logic [31:0] rd; logic er; int lt;
    xact(1, 0, 1, 9'h010, 32'h0BADF00D, 3'b010, rd, er, lt);
    xact(1, 1, 0, 9'h010, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'h0BADF00D || lt != 3) begin
      failures++;
      $display("FAIL lat3_basic got rdata=%h lat=%0d exp 0badf00d/3",
               rd, lt);
    end
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_re = 1'b1; if3.req_we = 1'b0;
    if3.req_addr = 9'h010; if3.req_funct3 = 3'b010;
    if3.rsp_ready = 1'b0;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    checks++;
    if (if3.rsp_valid !== 1'b0 || if3.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lat3_c1 got vld=%b rdy=%b exp 0/0",
               if3.rsp_valid, if3.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (if3.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_c2 got vld=%b exp 0", if3.rsp_valid);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (if3.rsp_valid !== 1'b1 || if3.rsp_rdata !== 32'h0BADF00D ||
          if3.req_ready !== 1'b0 || if3.rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL lat3_hold%0d got vld=%b rdata=%h rdy=%b exp 1/0badf00d/0",
                 k, if3.rsp_valid, if3.rsp_rdata, if3.req_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    if3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if3.rsp_valid !== 1'b0 || if3.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL lat3_release got vld=%b rdy=%b exp 0/1",
               if3.rsp_valid, if3.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lt;
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_re = 1'b1; if3.req_we = 1'b0;
    if3.req_addr = 9'h010; if3.req_funct3 = 3'b010;
    if3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (if3.rsp_valid !== 1'b0 || if3.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait got vld=%b rdy=%b exp 0/1",
               if3.rsp_valid, if3.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_re = 1'b0; if3.req_we = 1'b1;
    if3.req_addr = 9'h040; if3.req_wdata = 32'hCAFEF00D;
    if3.req_funct3 = 3'b010;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    xact(1, 1, 0, 9'h040, 32'h0, 3'b010, rd, er, lt);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || lt != 3) begin
      failures++;
      $display("FAIL rst_store_kept got rdata=%h err=%b lat=%0d exp cafef00d/0/3",
               rd, er, lt);
    end
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.req_re = 1'b0; if1.req_we = 1'b0;
    if1.req_addr = '0; if1.req_wdata = '0; if1.req_funct3 = '0;
    if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_re = 1'b0; if3.req_we = 1'b0;
    if3.req_addr = '0; if3.req_wdata = '0; if3.req_funct3 = '0;
    if3.rsp_ready = 1'b0;
    test_reset();
    test_sw_lw();
    test_misalign();
    test_byte();
    test_half();
    test_illegal();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
